// File: rtl/cp0_regs_if.sv
// Coprocessor-0 access bus between the pipeline (master) and the CP0 register file (slave).
// Inputs are single-cycle commit pulses with no backpressure; read data and status outputs are combinational.
interface cp0_regs_if #(
  parameter int HW_INT_NUM = 6
);
  logic [HW_INT_NUM-1:0] ext_int_in;
  logic                  wb_ex;
  logic [4:0]            wb_excode;
  logic [31:0]           wb_badvaddr;
  logic                  wb_bd;
  logic [31:0]           wb_pc;
  logic                  eret_flush;
  logic                  mtc0_we;
  logic [4:0]            c0_waddr;
  logic [31:0]           c0_wdata;
  logic [4:0]            c0_raddr;
  logic [31:0]           c0_rdata;
  logic [31:0]           epc_out;
  logic                  status_exl;
  logic                  int_req;

  modport master (
    output ext_int_in, wb_ex, wb_excode, wb_badvaddr, wb_bd, wb_pc,
    output eret_flush, mtc0_we, c0_waddr, c0_wdata, c0_raddr,
    input  c0_rdata, epc_out, status_exl, int_req
  );

  modport slave (
    input  ext_int_in, wb_ex, wb_excode, wb_badvaddr, wb_bd, wb_pc,
    input  eret_flush, mtc0_we, c0_waddr, c0_wdata, c0_raddr,
    output c0_rdata, epc_out, status_exl, int_req
  );
endinterface

// File: rtl/cp0_regs.sv
// MIPS-style CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC plus interrupt request.
// Define CP0_TIMER_INT_EN to build the Count/Compare timer and its TI interrupt on IP7.
module cp0_regs #(
  parameter int HW_INT_NUM = 6,
  parameter int COUNT_DIV  = 2
) (
  input  logic      clk,
  input  logic      reset,
  cp0_regs_if.slave bus
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;

  if (HW_INT_NUM < 1 || HW_INT_NUM > 6) begin : g_bad_hw_int_num
    $error("cp0_regs: HW_INT_NUM must be 1..6");
  end
  if (COUNT_DIV < 1 || COUNT_DIV > 16) begin : g_bad_count_div
    $error("cp0_regs: COUNT_DIV must be 1..16");
  end

  logic [7:0]            im_q, im_d;
  logic                  ie_q, ie_d;
  logic                  exl_q, exl_d;
  logic                  bd_q, bd_d;
  logic [4:0]            exc_q, exc_d;
  logic [1:0]            ip_sw_q, ip_sw_d;
  logic [HW_INT_NUM-1:0] ip_hw_q, ip_hw_d;
  logic [31:0]           epc_q, epc_d;
  logic [31:0]           badv_q, badv_d;

  logic                  wr_status;
  logic                  wr_cause;
  logic                  wr_epc;
  logic                  badv_load;

  logic                  ti;
  logic [31:0]           count_rd;
  logic [31:0]           compare_rd;
  logic [7:0]            ip;
  logic [31:0]           status_rd;
  logic [31:0]           cause_rd;
  logic [31:0]           rdata;

  assign wr_status = bus.mtc0_we && (bus.c0_waddr == ADDR_STATUS);
  assign wr_cause  = bus.mtc0_we && (bus.c0_waddr == ADDR_CAUSE);
  assign wr_epc    = bus.mtc0_we && (bus.c0_waddr == ADDR_EPC);
  assign badv_load = bus.wb_ex && ((bus.wb_excode == 5'h04) || (bus.wb_excode == 5'h05));

  // Writes are layered lowest priority first: MTC0, then ERET, then exception commit.
  always_comb begin
    im_d    = im_q;
    ie_d    = ie_q;
    exl_d   = exl_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    ip_sw_d = ip_sw_q;
    ip_hw_d = bus.ext_int_in;
    epc_d   = epc_q;
    badv_d  = badv_q;

    if (wr_status) begin
      im_d  = bus.c0_wdata[15:8];
      exl_d = bus.c0_wdata[1];
      ie_d  = bus.c0_wdata[0];
    end
    if (wr_cause) begin
      ip_sw_d = bus.c0_wdata[9:8];
    end
    if (wr_epc) begin
      epc_d = bus.c0_wdata;
    end

    if (bus.eret_flush) begin
      exl_d = 1'b0;
    end

    if (bus.wb_ex) begin
      exl_d = 1'b1;
      exc_d = bus.wb_excode;
      // A nested exception keeps the original return point and delay-slot flag.
      if (!exl_q) begin
        bd_d  = bus.wb_bd;
        epc_d = bus.wb_bd ? (bus.wb_pc - 32'd4) : bus.wb_pc;
      end else begin
        epc_d = epc_q;
      end
    end
    if (badv_load) begin
      badv_d = bus.wb_badvaddr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q    <= '0;
      ie_q    <= 1'b0;
      exl_q   <= 1'b0;
      bd_q    <= 1'b0;
      exc_q   <= '0;
      ip_sw_q <= '0;
      ip_hw_q <= '0;
      epc_q   <= '0;
      badv_q  <= '0;
    end else begin
      im_q    <= im_d;
      ie_q    <= ie_d;
      exl_q   <= exl_d;
      bd_q    <= bd_d;
      exc_q   <= exc_d;
      ip_sw_q <= ip_sw_d;
      ip_hw_q <= ip_hw_d;
      epc_q   <= epc_d;
      badv_q  <= badv_d;
    end
  end

`ifdef CP0_TIMER_INT_EN
  localparam logic [3:0] PRESC_LAST = 4'(COUNT_DIV - 1);

  logic [3:0]  presc_q, presc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        wr_count;
  logic        wr_compare;

  assign wr_count   = bus.mtc0_we && (bus.c0_waddr == ADDR_COUNT);
  assign wr_compare = bus.mtc0_we && (bus.c0_waddr == ADDR_COMPARE);

  always_comb begin
    presc_d   = (presc_q == PRESC_LAST) ? 4'd0 : (presc_q + 4'd1);
    count_d   = (presc_q == PRESC_LAST) ? (count_q + 32'd1) : count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (wr_count) begin
      count_d = bus.c0_wdata;
    end
    if (count_q == compare_q) begin
      ti_d = 1'b1;
    end
    // Rewriting Compare acknowledges the timer even if a match is seen this cycle.
    if (wr_compare) begin
      compare_d = bus.c0_wdata;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign ti         = ti_q;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  assign ti         = 1'b0;
  assign count_rd   = 32'd0;
  assign compare_rd = 32'd0;
`endif

  // Hardware lines occupy IP[2 +: HW_INT_NUM]; unused upper lines read zero, IP7 also carries TI.
  always_comb begin
    ip      = 8'h00;
    ip[1:0] = ip_sw_q;
    ip[7:2] = 6'(ip_hw_q);
    ip[7]   = ip[7] | ti;
  end

  assign status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_rd  = {bd_q, ti, 14'b0, ip, 1'b0, exc_q, 2'b0};

  always_comb begin
    rdata = 32'd0;
    case (bus.c0_raddr)
      ADDR_BADVADDR: rdata = badv_q;
      ADDR_COUNT:    rdata = count_rd;
      ADDR_COMPARE:  rdata = compare_rd;
      ADDR_STATUS:   rdata = status_rd;
      ADDR_CAUSE:    rdata = cause_rd;
      ADDR_EPC:      rdata = epc_q;
      default:       rdata = 32'd0;
    endcase
  end

  assign bus.c0_rdata   = rdata;
  assign bus.epc_out    = epc_q;
  assign bus.status_exl = exl_q;
  assign bus.int_req    = ie_q && !exl_q && ((ip & im_q) != 8'h00);

endmodule

// File: doc/cp0_regs.md
CP0_REGS -- requirements
Module: cp0_regs

Interface
REQ-001 Parameter HW_INT_NUM, default 6, number of hardware interrupt lines (legal 1..6), mapped to Cause.IP[2+HW_INT_NUM-1:2].
REQ-002 Parameter COUNT_DIV, default 2, clk cycles per Count increment (legal 1..16).
REQ-003 Port clk  input  1  clock; reset  input  1  reset, synchronous, active-high.
REQ-004 Port ext_int_in  input  HW_INT_NUM  level-sensitive hardware interrupt lines.
REQ-005 Ports wb_ex  input  1  exception commit; wb_excode  input  5  cause code; wb_badvaddr  input  32  faulting address; wb_bd  input  1  faulting instruction in delay slot; wb_pc  input  32  faulting PC.
REQ-006 Ports eret_flush  input  1  ERET commit; mtc0_we  input  1  MTC0 write; c0_waddr  input  5  write register number; c0_wdata  input  32  write data; c0_raddr  input  5  MFC0 read register number.
REQ-007 Ports c0_rdata  output  32  read data; epc_out  output  32  EPC value; status_exl  output  1  Status.EXL; int_req  output  1  interrupt pending to pipeline.

Function
REQ-008 Implemented registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); c0_rdata for any other c0_raddr SHALL be 0.
REQ-009 Status read format: bit22 BEV constant 1, [15:8] IM, [1] EXL, [0] IE, others 0; Cause: [31] BD, [30] TI, [15:8] IP, [6:2] ExcCode, others 0.
REQ-010 c0_rdata SHALL be combinational from current register state; a same-cycle write to the read register returns the old value.
REQ-011 Prescaler counts 0..COUNT_DIV-1 and wraps; Count SHALL increment by 1 (mod 2^32, 0xFFFFFFFF wraps to 0) in the cycle the prescaler equals COUNT_DIV-1.
REQ-012 MTC0 to Count SHALL load c0_wdata and override that cycle's increment; prescaler unaffected.
REQ-013 TI SHALL set the cycle after Count==Compare; MTC0 to Compare loads Compare and clears TI, with clear taking priority over set in the same cycle.
REQ-014 IP[2+i] SHALL be ext_int_in[i] registered one cycle; IP bits 7:2 above HW_INT_NUM read 0, except IP7 additionally ORs TI.
REQ-015 IP[1:0] SHALL be written only by MTC0 to Cause (c0_wdata[9:8]); other Cause bits are not software-writable.
REQ-016 int_req SHALL equal IE & ~EXL & |(IP & IM), combinational from registers.
REQ-017 On wb_ex: ExcCode <= wb_excode, EXL <= 1; if EXL was 0, BD <= wb_bd and EPC <= (wb_bd ? wb_pc-4 : wb_pc); if EXL was 1, BD and EPC unchanged.
REQ-018 BadVAddr SHALL load wb_badvaddr only when wb_ex=1 and wb_excode is 5'h04 (AdEL) or 5'h05 (AdES).
REQ-019 eret_flush SHALL clear EXL.
REQ-020 Priority in one cycle: wb_ex over eret_flush over MTC0 for every register field both can modify; an MTC0 to a field not touched by wb_ex still takes effect.
REQ-021 MTC0 to Status writes IM, EXL, IE; MTC0 to EPC/BadVAddr-writes: EPC writable, BadVAddr read-only.

Reset
REQ-022 On reset: Status.IM=0, EXL=0, IE=0; Cause all 0; Count=0; prescaler=0; Compare=32'hFFFFFFFF; EPC=0; BadVAddr=0; hence int_req=0, status_exl=0, epc_out=0.
REQ-023 Reset SHALL override all simultaneous wb_ex, eret_flush and MTC0 inputs.

Configuration
REQ-024 Macro CP0_TIMER_INT_EN defined: Count, Compare, prescaler and TI behave per REQ-011..014.
REQ-025 Macro CP0_TIMER_INT_EN undefined: Count/Compare/prescaler absent, reads of 9 and 11 return 0, writes ignored, TI constant 0, IP7 from ext_int_in only.

Verification
REQ-026 COUNT_DIV=2, after reset 10 cycles -> Count reads 5; MTC0 Count=0xFFFFFFFF then 2 cycles -> Count=0.
REQ-027 Compare=20, Status=0x0000_8001 -> TI=1 and int_req=1 one cycle after Count==20; MTC0 Compare=100 -> TI=0, int_req=0 next cycle.
REQ-028 wb_ex, excode=5'h04, bd=1, pc=0xBFC0_0104, badvaddr=0x1234_5673 -> EPC=0xBFC0_0100, BD=1, ExcCode=4, BadVAddr=0x1234_5673, EXL=1.
REQ-029 Second wb_ex (excode=5'h08, pc=0x8000_0200) while EXL=1 -> ExcCode=8, EPC and BD unchanged, BadVAddr unchanged; then eret_flush -> EXL=0.
REQ-030 wb_ex and MTC0 Status=0x0000_0000 same cycle -> EXL=1, IE=0, IM=0.
REQ-031 HW_INT_NUM=2, IM=0xFF, IE=1, ext_int_in=2'b10 -> Cause.IP=0x08 one cycle later, int_req=1; ext_int_in=0 -> IP=0 next cycle.
